pzvbus_credit_receiver: RTL

//  Downstream consumer of a pzvbus_if (valid + payload, no backpressure). Buffers every beat in a

---
 rtl/pzvbus_pkg.sv | 15 +
 rtl/pzvbus_if.sv | 17 +
 rtl/pzvbus_credit_buffer.sv | 81 ++++++++
 rtl/pzvbus_credit_receiver.sv | 88 ++++++++
 4 files changed

// File: rtl/pzvbus_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pzvbus_pkg
//  Description : Shared helpers for the pzvbus receive-side blocks.
//  Revision    : 1.0  initial release
// ============================================================================
package pzvbus_pkg;

    // Advance a circular index that wraps at an arbitrary (non power-of-two) depth.
    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned depth);
        return (idx == depth - 1) ? 0 : idx + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pzvbus_if.sv
`default_nettype none
// ============================================================================
//  Module      : pzvbus_if
//  Description : Valid + payload link with no backpressure; flow control is
//                credit based and lives outside the interface.
//  Revision    : 1.0  initial release
// ============================================================================
interface pzvbus_if #(
    parameter type PAYLOAD = logic
);
    logic   valid;
    PAYLOAD payload;

    modport master (output valid, output payload);
    modport slave  (input  valid, input  payload);
endinterface
`default_nettype wire

// File: rtl/pzvbus_credit_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : pzvbus_credit_buffer
//  Description : Flop-array FIFO with wrapping pointers and an occupancy
//                counter. Writes into a full FIFO are dropped unless a pop
//                frees the head slot in the same cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module pzvbus_credit_buffer
    import pzvbus_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int DEPTH = 4,
    localparam int CW   = $clog2(DEPTH + 1),
    localparam int PW   = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic [CW-1:0]    o_count,
    output logic             o_full
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_rptr;
    logic [PW-1:0]    r_wptr;
    logic [CW-1:0]    r_count;

    logic w_empty;
    logic w_full;
    logic w_wr;
    logic w_rd;

    // Occupancy is judged from the counter only, so non power-of-two depths work.
    always_comb begin
        w_empty = (r_count == '0);
        w_full  = (r_count == CW'(DEPTH));
        w_wr    = i_push && (!w_full || i_pop);
        w_rd    = i_pop && !w_empty;
    end

    // Storage needs no reset: contents are only visible while count is non-zero.
    always_ff @(posedge i_clk) begin
        if (w_wr) begin
            r_mem[r_wptr] <= i_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rptr  <= '0;
            r_wptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_wr) begin
                r_wptr <= PW'(wrap_inc(int'(r_wptr), DEPTH));
            end
            if (w_rd) begin
                r_rptr <= PW'(wrap_inc(int'(r_rptr), DEPTH));
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Head entry is masked to zero when empty so the reset value is clean.
    always_comb begin
        o_data  = w_empty ? '0 : r_mem[r_rptr];
        o_count = r_count;
        o_full  = w_full;
    end

endmodule
`default_nettype wire

// File: rtl/pzvbus_credit_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : pzvbus_credit_receiver
//  Description : Receive end of a credit-controlled pzvbus link. Buffers each
//                beat, re-issues it as valid/ready and returns one credit per
//                drained entry.
//  Revision    : 1.0  initial release
// ============================================================================
module pzvbus_credit_receiver
    import pzvbus_pkg::*;
#(
    parameter type PAYLOAD = logic,
    parameter int  DEPTH   = 4,
    localparam int W       = $bits(PAYLOAD),
    localparam int CW      = $clog2(DEPTH + 1)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    pzvbus_if.slave       slave_if,
    output logic          o_valid,
    input  logic          i_ready,
    output logic [W-1:0]  o_payload,
    output logic          o_credit_return,
    output logic [CW-1:0] o_count,
    output logic          o_overflow
);

    logic         w_push;
    logic         w_pop;
    logic         w_full;
    logic [W-1:0] w_data;
    logic         r_credit;
    logic         r_overflow;

    // Adapt the interface and derive the handshake.
    always_comb begin
        w_push  = slave_if.valid;
        w_data  = slave_if.payload;
        o_valid = (o_count != '0);
        w_pop   = o_valid && i_ready;
    end

    pzvbus_credit_buffer #(
        .WIDTH (W),
        .DEPTH (DEPTH)
    ) u_buffer (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (w_data),
        .o_data  (o_payload),
        .o_count (o_count),
        .o_full  (w_full)
    );

    // One credit pulse per pop, one cycle later; sticky flag for dropped beats.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_credit   <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_credit <= w_pop;
            if (w_push && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign o_credit_return = r_credit;
    assign o_overflow      = r_overflow;

`ifndef SYNTHESIS
    a_payload_hold: assert property (@(posedge i_clk) disable iff (i_rst)
        (o_valid && !i_ready) |=> $stable(o_payload));

    a_count_bound: assert property (@(posedge i_clk) disable iff (i_rst)
        o_count <= CW'(DEPTH));

`ifdef PZVBUS_STRICT_CREDITS
    // Opt-in: some environments deliberately provoke an overflow to exercise the sticky flag.
    a_no_overflow: assert property (@(posedge i_clk) disable iff (i_rst)
        !(w_push && w_full && !w_pop));
`endif
`endif

endmodule
`default_nettype wire
